// File: rtl/mem_bus_responder.sv
// mem_bus_responder: bus responder with internal RAM, external ROM decode and programmable wait states
module mem_bus_responder #(
    parameter int                          ADDR_W   = 13,
    parameter int                          DATA_W   = 8,
    parameter int                          RAM_AW   = 8,
    parameter logic [ADDR_W-RAM_AW-1:0]    RAM_BASE = 5'b11000,
    parameter int                          WAIT_CYC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_oe,
    output logic              ready,
    output logic              err,
    output logic              busy,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP, HOLD} state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                wr_op_q, wr_op_d;
    logic                ram_sel_q, ram_sel_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   data_out_q, data_out_d;
    logic                data_oe_q, data_oe_d;
    logic                ready_q, ready_d;
    logic                err_q, err_d;
    logic                mem_we;
    logic [DATA_W-1:0]   mem [2**RAM_AW];

    // next-state and output decode; strobe drop during WAIT aborts before the counter is considered
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wr_op_d    = wr_op_q;
        ram_sel_d  = ram_sel_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        data_out_d = data_out_q;
        data_oe_d  = data_oe_q;
        ready_d    = 1'b0;
        err_d      = 1'b0;
        mem_we     = 1'b0;
        case (state_q)
            IDLE: begin
                if (rd && wr) begin
                    err_d   = 1'b1;
                    state_d = HOLD;
                end else if (rd || wr) begin
                    wr_op_d   = wr;
                    addr_d    = addr;
                    wdata_d   = data_in;
                    ram_sel_d = addr[ADDR_W-1:RAM_AW] == RAM_BASE;
                    state_d   = (WAIT_CYC == 0) ? RESP : WAIT;
                    cnt_d     = (WAIT_CYC == 0) ? 4'd0 : 4'(WAIT_CYC - 1);
                end
            end
            WAIT: begin
                if (wr_op_q ? !wr : !rd) state_d = IDLE;
                else if (cnt_q == 4'd0) state_d = RESP;
                else cnt_d = cnt_q - 4'd1;
            end
            RESP: begin
                ready_d = 1'b1;
                state_d = HOLD;
                if (wr_op_q) begin
                    err_d  = !ram_sel_q;
                    mem_we = ram_sel_q;
                end else begin
                    data_out_d = ram_sel_q ? mem[addr_q[RAM_AW-1:0]] : rom_data;
                    data_oe_d  = 1'b1;
                end
            end
            HOLD: begin
                if (!rd && !wr) begin
                    state_d   = IDLE;
                    data_oe_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // control and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            wr_op_q    <= 1'b0;
            ram_sel_q  <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            data_out_q <= '0;
            data_oe_q  <= 1'b0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_op_q    <= wr_op_d;
            ram_sel_q  <= ram_sel_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            data_out_q <= data_out_d;
            data_oe_q  <= data_oe_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
        end
    end

    // data RAM, not reset; reset suppresses a write pending in RESP
    always_ff @(posedge clk) begin
        if (!rst && mem_we) mem[addr_q[RAM_AW-1:0]] <= wdata_q;
    end

    assign data_out = data_out_q;
    assign data_oe  = data_oe_q;
    assign ready    = ready_q;
    assign err      = err_q;
    assign busy     = state_q != IDLE;
    assign rom_addr = addr_q;
endmodule

// File: tb/tb_mem_bus_responder.sv
// tb_mem_bus_responder: directed checks of three responders with WAIT_CYC 1, 3 and 0
module tb_mem_bus_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd [3];
    logic        wr [3];
    logic [12:0] addr [3];
    logic [7:0]  data_in [3];
    logic [7:0]  data_out [3];
    logic        data_oe [3];
    logic        ready [3];
    logic        err [3];
    logic        busy [3];
    logic [12:0] rom_addr [3];
    logic [7:0]  rom_data [3];
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign rom_data[g] = rom_addr[g][7:0] ^ 8'h2E;
        mem_bus_responder #(.WAIT_CYC(g == 0 ? 1 : g == 1 ? 3 : 0)) u (
            .clk(clk), .rst(rst), .rd(rd[g]), .wr(wr[g]), .addr(addr[g]),
            .data_in(data_in[g]), .data_out(data_out[g]), .data_oe(data_oe[g]),
            .ready(ready[g]), .err(err[g]), .busy(busy[g]),
            .rom_addr(rom_addr[g]), .rom_data(rom_data[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // one full access; latency counted in negedges after the drive point, bounded
    task automatic xfer(input int i, input bit w, input logic [12:0] a, input logic [7:0] d,
                        output logic [7:0] q, output logic e, output int lat);
        rd[i] = !w; wr[i] = w; addr[i] = a; data_in[i] = d;
        lat = -1; q = '0; e = 1'b0;
        for (int k = 1; k <= 20 && lat < 0; k++) begin
            @(negedge clk);
            if (k == 1) begin addr[i] = ~a; data_in[i] = ~d; end
            if (ready[i]) begin lat = k; q = data_out[i]; e = err[i]; end
        end
        rd[i] = 1'b0; wr[i] = 1'b0;
        tick(1);
    endtask

    initial begin
        logic [7:0] q;
        logic       e;
        int         lat;
        int         cnt;
        for (int i = 0; i < 3; i++) begin
            rd[i] = 0; wr[i] = 0; addr[i] = 0; data_in[i] = 0;
        end
        tick(2);
        for (int i = 0; i < 3; i++)
            chk($sformatf("reset_%0d", i),
                {data_out[i], data_oe[i], ready[i], err[i], busy[i], rom_addr[i]}, 0);
        rst = 1'b0;
        tick(1);
        // RAM write then read with data_oe held until rd drops
        xfer(0, 1, 13'h1805, 8'hA5, q, e, lat);
        chk("wr_lat", lat, 3);
        chk("wr_err", e, 0);
        chk("wr_oe", data_oe[0], 0);
        rd[0] = 1; addr[0] = 13'h1805;
        tick(2);
        chk("rd_early", {ready[0], busy[0]}, 2'b01);
        tick(1);
        chk("rd_ready", {ready[0], data_oe[0], data_out[0]}, {2'b11, 8'hA5});
        tick(1);
        chk("rd_hold", {ready[0], data_oe[0], busy[0]}, 3'b011);
        rd[0] = 0;
        tick(1);
        chk("rd_release", {data_oe[0], busy[0], data_out[0]}, {2'b00, 8'hA5});
        // ROM read and illegal ROM write
        xfer(0, 1, 13'h1812, 8'h99, q, e, lat);
        xfer(0, 0, 13'h0012, 8'h00, q, e, lat);
        chk("rom_rd", {q, e, rom_addr[0]}, {8'h3C, 1'b0, 13'h0012});
        chk("rom_rd_lat", lat, 3);
        xfer(0, 1, 13'h0012, 8'h55, q, e, lat);
        chk("rom_wr_err", {e, 8'(lat)}, {1'b1, 8'd3});
        xfer(0, 0, 13'h1812, 8'h00, q, e, lat);
        chk("ram_untouched", q, 8'h99);
        // both strobes together
        rd[0] = 1; wr[0] = 1; addr[0] = 13'h1805;
        tick(1);
        chk("both_err", {err[0], ready[0], busy[0]}, 3'b101);
        tick(1);
        chk("both_err_pulse", {err[0], ready[0], busy[0]}, 3'b001);
        cnt = 0;
        repeat (3) begin tick(1); if (ready[0] || err[0]) cnt++; end
        chk("both_quiet", cnt, 0);
        rd[0] = 0;
        tick(1);
        chk("both_busy_wr", busy[0], 1);
        wr[0] = 0;
        tick(1);
        chk("both_idle", busy[0], 0);
        // abort of a WAIT_CYC=3 write
        xfer(1, 1, 13'h1810, 8'h11, q, e, lat);
        chk("w3_lat", lat, 5);
        wr[1] = 1; addr[1] = 13'h1810; data_in[1] = 8'h77;
        tick(2);
        chk("abort_wait", {ready[1], busy[1]}, 2'b01);
        wr[1] = 0;
        tick(1);
        chk("abort_idle", {ready[1], err[1], busy[1]}, 3'b000);
        xfer(1, 0, 13'h1810, 8'h00, q, e, lat);
        chk("abort_data", q, 8'h11);
        // rd held: exactly one ready
        rd[0] = 1; addr[0] = 13'h1805; cnt = 0;
        repeat (6) begin tick(1); if (ready[0]) cnt++; end
        chk("held_one_ready", cnt, 1);
        chk("held_busy", busy[0], 1);
        rd[0] = 0;
        tick(1);
        chk("held_idle", busy[0], 0);
        xfer(0, 0, 13'h1805, 8'h00, q, e, lat);
        chk("held_reaccess", {q, 8'(lat)}, {8'hA5, 8'd3});
        // reset during WAIT of a write
        xfer(1, 1, 13'h18FF, 8'h42, q, e, lat);
        xfer(1, 0, 13'h18FF, 8'h00, q, e, lat);
        chk("pre_rst_rd", q, 8'h42);
        wr[1] = 1; addr[1] = 13'h18FF; data_in[1] = 8'hBD;
        tick(1);
        rst = 1;
        tick(1);
        chk("rst_wait_outs", {data_out[1], data_oe[1], ready[1], err[1], busy[1], rom_addr[1]}, 0);
        rst = 0; wr[1] = 0;
        tick(1);
        xfer(1, 0, 13'h18FF, 8'h00, q, e, lat);
        chk("rst_wait_data", q, 8'h42);
        // WAIT_CYC=0: latency and reset during RESP
        xfer(2, 1, 13'h18FF, 8'h42, q, e, lat);
        chk("w0_lat", lat, 2);
        wr[2] = 1; addr[2] = 13'h18FF; data_in[2] = 8'hBD;
        tick(1);
        rst = 1;
        tick(1);
        chk("rst_resp_outs", {ready[2], err[2], busy[2], rom_addr[2]}, 0);
        rst = 0; wr[2] = 0;
        tick(1);
        xfer(2, 0, 13'h18FF, 8'h00, q, e, lat);
        chk("rst_resp_data", {q, 8'(lat)}, {8'h42, 8'd2});
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
